camera_frame_writer: RTL

Write-side counterpart of the VGA display path: drains camera pixels from a show-ahead capture FIFO and writes one full frame per camera frame-start into SDRAM through the controller's write port. Alternates between two frame buffers so the display side always reads the last complete frame. Runs entirely in the SDRAM clock domain and reports which bank holds the newest finished frame.

---
 rtl/camera_frame_writer.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/camera_frame_writer.sv
// Drains a show-ahead camera FIFO into SDRAM, one full frame per camera frame-start.
// Ping-pongs between two frame buffers and reports the bank holding the newest complete frame.
module camera_frame_writer #(
  parameter int                    IMG_WIDTH  = 320,
  parameter int                    IMG_HEIGHT = 240,
  parameter int                    DATA_WIDTH = 16,
  parameter int                    ADDR_WIDTH = 24,
  parameter logic [ADDR_WIDTH-1:0] BANK0_BASE = 24'h000000,
  parameter logic [ADDR_WIDTH-1:0] BANK1_BASE = 24'h020000
) (
  input  logic                  clk_sdram,
  input  logic                  rst,
  input  logic                  sdram_ready,
  output logic                  enable_write_mode,
  output logic                  sdram_write_valid,
  input  logic                  sdram_write_ready,
  output logic [DATA_WIDTH-1:0] sdram_write_data,
  output logic [ADDR_WIDTH-1:0] sdram_write_addr,
  input  logic                  frame_start,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_read_data,
  output logic                  fifo_read_enable,
  output logic                  frame_written,
  output logic                  frame_dropped,
  output logic                  display_bank,
  output logic                  frame_valid
);

  localparam int IMG_SIZE = IMG_WIDTH * IMG_HEIGHT;
  localparam int CNT_W    = $clog2(IMG_SIZE + 1);
  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(IMG_SIZE - 1);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_FRAME,
    START_WRITE,
    WRITING,
    FRAME_DONE
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] count;
  logic             write_bank;
  logic             ready_seen;
  logic             fs_sync1;
  logic             fs_sync2;
  logic             fs_prev;
  logic             fs_edge;
  logic             accept;
  logic [ADDR_WIDTH-1:0] bank_base;

  assign fs_edge   = fs_sync2 & ~fs_prev;
  assign bank_base = write_bank ? BANK1_BASE : BANK0_BASE;

  // frame_start comes from the camera clock domain, so it is resynchronised before edge detection
  always_ff @(posedge clk_sdram) begin
    if (rst) begin
      fs_sync1   <= 1'b0;
      fs_sync2   <= 1'b0;
      fs_prev    <= 1'b0;
      ready_seen <= 1'b0;
    end else begin
      fs_sync1   <= frame_start;
      fs_sync2   <= fs_sync1;
      fs_prev    <= fs_sync2;
      ready_seen <= ready_seen | sdram_ready;
    end
  end

  always_ff @(posedge clk_sdram) begin
    if (rst) begin
      state        <= IDLE;
      count        <= '0;
      write_bank   <= 1'b0;
      display_bank <= 1'b0;
      frame_valid  <= 1'b0;
    end else begin
      state <= state_next;
      if (state == START_WRITE) begin
        count <= '0;
      end else if (accept) begin
        count <= count + CNT_W'(1);
      end
      if (state == FRAME_DONE) begin
        display_bank <= write_bank;
        write_bank   <= ~write_bank;
        frame_valid  <= 1'b1;
      end
    end
  end

  // Completion wins over a simultaneous frame_start edge; that edge is then consumed
  always_comb begin
    state_next        = state;
    accept            = 1'b0;
    enable_write_mode = 1'b0;
    sdram_write_valid = 1'b0;
    sdram_write_data  = '0;
    sdram_write_addr  = '0;
    fifo_read_enable  = 1'b0;
    frame_written     = 1'b0;
    frame_dropped     = 1'b0;
    case (state)
      IDLE: begin
        if (ready_seen) state_next = WAIT_FRAME;
      end
      WAIT_FRAME: begin
        fifo_read_enable = !fifo_empty;
        if (fs_edge) state_next = START_WRITE;
      end
      START_WRITE: begin
        enable_write_mode = 1'b1;
        state_next        = WRITING;
      end
      WRITING: begin
        enable_write_mode = 1'b1;
        sdram_write_valid = !fifo_empty;
        if (!fifo_empty) begin
          sdram_write_data = fifo_read_data;
          sdram_write_addr = bank_base + ADDR_WIDTH'(count);
        end
        accept           = !fifo_empty && sdram_write_ready;
        fifo_read_enable = accept;
        if (accept && (count == LAST_COUNT)) begin
          state_next = FRAME_DONE;
        end else if (fs_edge) begin
          state_next    = START_WRITE;
          frame_dropped = 1'b1;
        end
      end
      FRAME_DONE: begin
        frame_written = 1'b1;
        state_next    = WAIT_FRAME;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule
